// File: rtl/codec_init_sequencer_if.sv
// Command bus between codec_init_sequencer (master) and the I2C_Command single-write engine
// (slave).
interface codec_init_sequencer_if;
    logic [7:0] cmd_slave_addr;
    logic [7:0] cmd_register;
    logic [7:0] cmd_data;
    logic       cmd_enable;
    logic       cmd_free;

    modport master (
        output cmd_slave_addr,
        output cmd_register,
        output cmd_data,
        output cmd_enable,
        input  cmd_free
    );

    modport slave (
        input  cmd_slave_addr,
        input  cmd_register,
        input  cmd_data,
        input  cmd_enable,
        output cmd_free
    );
endinterface

// File: rtl/codec_init_sequencer.sv
// Walks the WM8750 init table through I2C_Command after reset, then serves runtime user writes.
// Define I2C_SEQ_RETRY_EN to retry accept timeouts up to RETRIES times before faulting.
module codec_init_sequencer #(
    parameter logic [7:0]  SLAVE_ADDR     = 8'h34,
    parameter int unsigned NUM_ENTRIES    = 8,
    parameter int unsigned GAP_CYCLES     = 256,
    parameter int unsigned ACCEPT_TIMEOUT = 1024,
    parameter int unsigned DONE_TIMEOUT   = 65536,
    parameter int unsigned RETRIES        = 3
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    codec_init_sequencer_if.master        cmd,
    input  logic                          user_req,
    input  logic [6:0]                    user_reg,
    input  logic [8:0]                    user_val,
    output logic                          user_ack,
    output logic                          init_done,
    output logic                          busy,
    output logic                          fault,
    output logic [5:0]                    cur_idx
);

    typedef enum logic [2:0] {
        StGap,
        StReady,
        StIssue,
        StWaitAccept,
        StWaitDone,
        StFault
    } state_e;

    localparam logic [16:0] GapLast     = 17'(GAP_CYCLES - 1);
    localparam logic [16:0] AcceptLimit = 17'(ACCEPT_TIMEOUT);
    localparam logic [16:0] DoneLimit   = 17'(DONE_TIMEOUT);
    localparam logic [5:0]  LastIdx     = 6'(NUM_ENTRIES - 1);

    state_e      state_q;
    logic [16:0] timer_q;
    logic [5:0]  cur_idx_q;
    logic        tbl_done_q;
    logic        is_user_q;
    logic        enable_q;
    logic [7:0]  reg_q;
    logic [7:0]  data_q;
    logic        user_ack_q;
    logic        init_done_q;
    logic        busy_q;
    logic        fault_q;
    logic [15:0] tbl_word;

`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned RetryW = (RETRIES < 2) ? 1 : $clog2(RETRIES + 1);
    logic [RetryW-1:0] retry_q;
`else
    logic unused_retries;
    assign unused_retries = ^RETRIES;
`endif

    // Init ROM, {reg7, val9}; entry 0 resets the codec.
    always_comb begin
        tbl_word = 16'h0000;
        case (cur_idx_q)
            6'd0:    tbl_word = {7'h0F, 9'h000};
            6'd1:    tbl_word = {7'h19, 9'h0FC};
            6'd2:    tbl_word = {7'h1A, 9'h1F8};
            6'd3:    tbl_word = {7'h07, 9'h002};
            6'd4:    tbl_word = {7'h08, 9'h000};
            6'd5:    tbl_word = {7'h05, 9'h000};
            6'd6:    tbl_word = {7'h22, 9'h150};
            6'd7:    tbl_word = {7'h25, 9'h150};
            default: tbl_word = 16'h0000;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StGap;
            timer_q     <= '0;
            cur_idx_q   <= '0;
            tbl_done_q  <= 1'b0;
            is_user_q   <= 1'b0;
            enable_q    <= 1'b0;
            reg_q       <= '0;
            data_q      <= '0;
            user_ack_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            fault_q     <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            enable_q   <= 1'b0;
            user_ack_q <= 1'b0;
            timer_q    <= (timer_q == '1) ? timer_q : timer_q + 17'd1;
            unique case (state_q)
                StGap: begin
                    if (timer_q >= GapLast) begin
                        timer_q <= '0;
                        if (!tbl_done_q) begin
                            state_q   <= StIssue;
                            enable_q  <= 1'b1;
                            is_user_q <= 1'b0;
                            reg_q     <= tbl_word[15:8];
                            data_q    <= tbl_word[7:0];
                        end else begin
                            state_q     <= StReady;
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                StReady: begin
                    // A busy bus only delays the request; there is no timeout here.
                    if (user_req && cmd.cmd_free) begin
                        state_q   <= StIssue;
                        enable_q  <= 1'b1;
                        timer_q   <= '0;
                        is_user_q <= 1'b1;
                        reg_q     <= {user_reg, user_val[8]};
                        data_q    <= user_val[7:0];
                        busy_q    <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StWaitAccept;
                end
                StWaitAccept: begin
                    if (!cmd.cmd_free) begin
                        state_q <= StWaitDone;
                        timer_q <= '0;
                    end else if (timer_q >= AcceptLimit) begin
`ifdef I2C_SEQ_RETRY_EN
                        if (retry_q < RetryW'(RETRIES)) begin
                            retry_q  <= retry_q + 1'b1;
                            state_q  <= StIssue;
                            enable_q <= 1'b1;
                            timer_q  <= '0;
                        end else begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= StFault;
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end
                end
                StWaitDone: begin
                    if (cmd.cmd_free) begin
                        state_q <= StGap;
                        timer_q <= '0;
`ifdef I2C_SEQ_RETRY_EN
                        retry_q <= '0;
`endif
                        if (is_user_q) begin
                            user_ack_q <= 1'b1;
                        end else if (cur_idx_q == LastIdx) begin
                            tbl_done_q <= 1'b1;
                        end else begin
                            cur_idx_q <= cur_idx_q + 6'd1;
                        end
                    end else if (timer_q >= DoneLimit) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StFault;
                    fault_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_slave_addr = SLAVE_ADDR;
    assign cmd.cmd_register   = reg_q;
    assign cmd.cmd_data       = data_q;
    assign cmd.cmd_enable     = enable_q;
    assign user_ack           = user_ack_q;
    assign init_done          = init_done_q;
    assign busy               = busy_q;
    assign fault              = fault_q;
    assign cur_idx            = cur_idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: table-driven writes checked through a scoreboard against a
// behavioural I2C_Command model, plus timeout and reset corner sequences.
module tb_codec_init_sequencer;

    localparam logic [7:0]  SlaveAddr     = 8'h34;
    localparam int unsigned NumEntries    = 8;
    localparam int unsigned GapCycles     = 256;
    localparam int unsigned AcceptTimeout = 1024;
    localparam int unsigned DoneTimeout   = 65536;
    localparam int unsigned Retries       = 3;
    localparam int unsigned AcceptLat     = 3;
    localparam int unsigned DoneLat       = 200;
    localparam int unsigned NumUser       = 4;
`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned AcceptPulses  = Retries + 1;
`else
    localparam int unsigned AcceptPulses  = 1;
`endif

    localparam int SelInit = 0;
    localparam int SelFault = 1;
    localparam int SelAck = 2;
    localparam int SelEn = 3;

    typedef enum int {ModeNormal, ModeNeverAccept, ModeAcceptSecond, ModeNeverDone} mode_e;

    typedef struct {
        logic [6:0] reg7;
        logic [8:0] val9;
        logic [7:0] exp_reg;
        logic [7:0] exp_data;
    } vec_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       user_req;
    logic [6:0] user_reg;
    logic [8:0] user_val;
    logic       user_ack;
    logic       init_done;
    logic       busy;
    logic       fault;
    logic [5:0] cur_idx;

    codec_init_sequencer_if cmd_bus ();

    codec_init_sequencer #(
        .SLAVE_ADDR     (SlaveAddr),
        .NUM_ENTRIES    (NumEntries),
        .GAP_CYCLES     (GapCycles),
        .ACCEPT_TIMEOUT (AcceptTimeout),
        .DONE_TIMEOUT   (DoneTimeout),
        .RETRIES        (Retries)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd       (cmd_bus),
        .user_req  (user_req),
        .user_reg  (user_reg),
        .user_val  (user_val),
        .user_ack  (user_ack),
        .init_done (init_done),
        .busy      (busy),
        .fault     (fault),
        .cur_idx   (cur_idx)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned pulses = 0;
    int unsigned fall_cyc = 0;
    int unsigned rise_cyc = 0;
    mode_e       mode = ModeNormal;
    logic [15:0] sb_q[$];
    vec_t        tbl[NumEntries];
    vec_t        uvec[NumUser];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_flag(input string name, input int sel, input int unsigned bound,
                             output int unsigned at);
        logic        v;
        logic        hit;
        int unsigned i;
        hit = 1'b0;
        i = 0;
        at = 0;
        while (!hit && i < bound) begin
            @(negedge sys_clk);
            case (sel)
                SelInit:  v = init_done;
                SelFault: v = fault;
                SelAck:   v = user_ack;
                default:  v = cmd_bus.cmd_enable;
            endcase
            if (v === 1'b1) begin
                hit = 1'b1;
                at = cyc;
            end
            i++;
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no rise within %0d cycles", name, bound);
        end
    endtask

    // Behavioural I2C_Command: accepts AcceptLat cycles after enable, finishes DoneLat later.
    initial begin : engine_model
        int unsigned mcnt;
        logic [7:0]  held_reg;
        logic [7:0]  held_data;
        mcnt = 0;
        cmd_bus.cmd_free = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n !== 1'b1) begin
                mcnt = 0;
                cmd_bus.cmd_free = 1'b1;
            end else if (cmd_bus.cmd_enable === 1'b1) begin
                mcnt++;
                if (mode == ModeNeverAccept || (mode == ModeAcceptSecond && mcnt == 1)) begin
                    // leave free high so the accept timer expires
                end else begin
                    held_reg = cmd_bus.cmd_register;
                    held_data = cmd_bus.cmd_data;
                    repeat (AcceptLat) @(negedge sys_clk);
                    cmd_bus.cmd_free = 1'b0;
                    fall_cyc = cyc;
                    if (mode == ModeNeverDone && mcnt >= 3) begin
                        while (sys_rst_n === 1'b1) @(negedge sys_clk);
                        cmd_bus.cmd_free = 1'b1;
                        mcnt = 0;
                    end else begin
                        repeat (DoneLat - 1) @(negedge sys_clk);
                        check("operand_hold", 32'({cmd_bus.cmd_register, cmd_bus.cmd_data}),
                              32'({held_reg, held_data}));
                        @(negedge sys_clk);
                        cmd_bus.cmd_free = 1'b1;
                        rise_cyc = cyc;
                    end
                end
            end
        end
    end

    // Scoreboard consumer: every enable pulse must match the oldest pending write.
    initial begin : monitor
        logic [15:0] exp;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && cmd_bus.cmd_enable === 1'b1) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_enable: reg 0x%0h data 0x%0h, none pending",
                             cmd_bus.cmd_register, cmd_bus.cmd_data);
                end else begin
                    exp = sb_q.pop_front();
                    check("cmd_register", 32'(cmd_bus.cmd_register), 32'(exp[15:8]));
                    check("cmd_data", 32'(cmd_bus.cmd_data), 32'(exp[7:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input mode_e m);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        mode = m;
        pulses = 0;
        sb_q.delete();
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic push_table(input int unsigned first, input int unsigned last);
        for (int unsigned i = first; i <= last; i++) begin
            sb_q.push_back({tbl[i].exp_reg, tbl[i].exp_data});
        end
    endtask

    task automatic run_user(input int v);
        int unsigned t_ack;
        sb_q.push_back({uvec[v].exp_reg, uvec[v].exp_data});
        user_reg = uvec[v].reg7;
        user_val = uvec[v].val9;
        user_req = 1'b1;
        wait_flag("user_ack", SelAck, 3000, t_ack);
        user_req = 1'b0;
        #1;
        check("ack_after_free_rise", t_ack - rise_cyc, 1);
        @(negedge sys_clk);
        check("ack_width", 32'(user_ack), 0);
    endtask

    initial begin : main
        int unsigned t0;
        int unsigned t_en;
        int unsigned t_done;
        int unsigned t_f;

        // {reg7, val9} and the hand-packed {reg7, val9[8]} / val9[7:0] bytes
        tbl[0] = '{7'h0F, 9'h000, 8'h1E, 8'h00};
        tbl[1] = '{7'h19, 9'h0FC, 8'h32, 8'hFC};
        tbl[2] = '{7'h1A, 9'h1F8, 8'h35, 8'hF8};
        tbl[3] = '{7'h07, 9'h002, 8'h0E, 8'h02};
        tbl[4] = '{7'h08, 9'h000, 8'h10, 8'h00};
        tbl[5] = '{7'h05, 9'h000, 8'h0A, 8'h00};
        tbl[6] = '{7'h22, 9'h150, 8'h45, 8'h50};
        tbl[7] = '{7'h25, 9'h150, 8'h4B, 8'h50};
        uvec[0] = '{7'h05, 9'h1FF, 8'h0B, 8'hFF};
        uvec[1] = '{7'h0A, 9'h100, 8'h15, 8'h00};
        uvec[2] = '{7'h7F, 9'h0FF, 8'hFE, 8'hFF};
        uvec[3] = '{7'h00, 9'h001, 8'h00, 8'h01};

        sys_rst_n = 1'b1;
        user_req = 1'b0;
        user_reg = '0;
        user_val = '0;
        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);

        check("rst_enable", 32'(cmd_bus.cmd_enable), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_user_ack", 32'(user_ack), 0);
        check("rst_cur_idx", 32'(cur_idx), 0);
        check("rst_cmd_register", 32'(cmd_bus.cmd_register), 0);
        check("rst_cmd_data", 32'(cmd_bus.cmd_data), 0);
        check("slave_addr", 32'(cmd_bus.cmd_slave_addr), 32'h34);

        // Init walk with a user request already pending: it must wait for init_done.
        push_table(0, NumEntries - 1);
        sb_q.push_back({uvec[0].exp_reg, uvec[0].exp_data});
        user_reg = uvec[0].reg7;
        user_val = uvec[0].val9;
        user_req = 1'b1;
        sys_rst_n = 1'b1;
        t0 = cyc;
        wait_flag("first_enable", SelEn, 2000, t_en);
        check("first_enable_gap", t_en - t0, GapCycles);
        wait_flag("init_done", SelInit, 20000, t_done);
        #1;
        check("init_done_after_gap", t_done - rise_cyc, GapCycles + 1);
        check("init_pulses", pulses, NumEntries);
        check("last_cur_idx", 32'(cur_idx), NumEntries - 1);
        check("ready_not_busy", 32'(busy), 0);
        wait_flag("user_enable", SelEn, 10, t_en);
        check("user_enable_after_init", t_en - t_done, 1);
        check("user_busy", 32'(busy), 1);
        wait_flag("user_ack0", SelAck, 3000, t0);
        user_req = 1'b0;
        #1;
        check("ack0_after_free_rise", t0 - rise_cyc, 1);
        @(negedge sys_clk);
        check("ack0_width", 32'(user_ack), 0);
        check("init_done_sticky", 32'(init_done), 1);
        for (int v = 1; v < NumUser; v++) begin
            run_user(v);
        end
        check("sb_empty_init_user", sb_q.size(), 0);

        // Engine never accepts: fault after the accept timeout (and retries, if enabled).
        apply_reset(ModeNeverAccept);
        for (int unsigned i = 0; i < AcceptPulses; i++) push_table(0, 0);
        sys_rst_n = 1'b1;
        wait_flag("accept_enable", SelEn, 2000, t_en);
        wait_flag("accept_fault", SelFault, 8000, t_f);
        check("accept_fault_time", t_f - t_en, AcceptPulses * (AcceptTimeout + 1));
        repeat (500) @(negedge sys_clk);
        #1;
        check("accept_pulses", pulses, AcceptPulses);
        check("accept_fault_sticky", 32'(fault), 1);
        check("accept_fault_busy", 32'(busy), 0);
        check("accept_init_done", 32'(init_done), 0);

`ifdef I2C_SEQ_RETRY_EN
        // First pulse ignored, retry accepted: the walk completes without fault.
        apply_reset(ModeAcceptSecond);
        push_table(0, 0);
        push_table(0, NumEntries - 1);
        sys_rst_n = 1'b1;
        wait_flag("retry_init_done", SelInit, 12000, t_done);
        #1;
        check("retry_no_fault", 32'(fault), 0);
        check("retry_pulses", pulses, NumEntries + 1);
        check("retry_sb_empty", sb_q.size(), 0);
`endif

        // Engine accepts entry 2 but never finishes: async reset in WAIT_DONE, then timeout.
        apply_reset(ModeNeverDone);
        push_table(0, 2);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) wait_flag("hang_enable", SelEn, 2000, t_en);
        repeat (100) @(negedge sys_clk);
        check("hang_busy", 32'(busy), 1);
        check("hang_cur_idx", 32'(cur_idx), 2);
        check("hang_cmd_register", 32'(cmd_bus.cmd_register), 32'(tbl[2].exp_reg));
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_enable", 32'(cmd_bus.cmd_enable), 0);
        check("async_rst_busy", 32'(busy), 1);
        check("async_rst_cur_idx", 32'(cur_idx), 0);
        check("async_rst_cmd_register", 32'(cmd_bus.cmd_register), 0);
        check("async_rst_cmd_data", 32'(cmd_bus.cmd_data), 0);
        check("async_rst_fault", 32'(fault), 0);
        repeat (2) @(negedge sys_clk);
        pulses = 0;
        sb_q.delete();
        push_table(0, 2);
        sys_rst_n = 1'b1;
        t0 = cyc;
        wait_flag("restart_enable", SelEn, 2000, t_en);
        check("restart_gap", t_en - t0, GapCycles);
        wait_flag("done_fault", SelFault, 70000, t_f);
        #1;
        check("done_fault_time", t_f - fall_cyc, DoneTimeout + 2);
        repeat (300) @(negedge sys_clk);
        #1;
        check("done_pulses", pulses, 3);
        check("done_sb_empty", sb_q.size(), 0);
        check("done_fault_busy", 32'(busy), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("final_rst_fault", 32'(fault), 0);
        check("final_rst_busy", 32'(busy), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
